// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence-detector path: default widths and a
// saturating increment used by the statistics counters.
package seq_det_pkg;

  localparam int unsigned TS_WIDTH_DEF   = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned CNT_WIDTH_DEF  = 16;

  // Increment value, holding at the all-ones value of a counter that is
  // `width` bits wide (width 1..32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] max_val;
    if (width >= 32) begin
      max_val = '1;
    end else begin
      max_val = (32'd1 << width) - 32'd1;
    end
    if (value >= max_val) begin
      return max_val;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/seq_evt_fifo.sv
// First-word-fall-through event queue. Pointers carry one extra wrap bit so
// full and empty fall out of a pointer compare; occupancy is their difference.
module seq_evt_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              wr_data,
  output logic [DW-1:0]              rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

  // A push into a full queue is only legal when the head leaves the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Head is read straight from storage; zero when nothing is queued.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; clear wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset because empty masks the output.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/seq_match_reporter.sv
// Timestamps each detector hit, queues it for a valid/ready consumer and keeps
// saturating match/drop statistics plus a sticky overflow flag.
module seq_match_reporter
  import seq_det_pkg::*;
#(
  parameter int unsigned TS_WIDTH   = TS_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hit_in,
  input  logic                          en,
  input  logic                          clr,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [TS_WIDTH-1:0]           evt_ts,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          match_count,
  output logic [CNT_WIDTH-1:0]          drop_count,
  output logic                          overflow
);

  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [CNT_WIDTH-1:0] match_count_q, match_count_d;
  logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic                 overflow_q, overflow_d;

  logic hit;
  logic pop;
  logic push;
  logic drop;
  logic fifo_full;
  logic fifo_empty;

  assign hit       = en & hit_in;
  assign evt_valid = ~fifo_empty;
  assign pop       = evt_valid & evt_ready;
  assign push      = hit & (~fifo_full | pop);
  assign drop      = hit & fifo_full & ~pop;

  seq_evt_fifo #(
    .DW    (TS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .push    (push),
    .pop     (pop),
    .wr_data (ts_q),
    .rd_data (evt_ts),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Timestamp, statistics and overflow next state; clear overrides a same-cycle hit.
  always_comb begin
    ts_d          = ts_q;
    match_count_d = match_count_q;
    drop_count_d  = drop_count_q;
    overflow_d    = overflow_q;
    if (clr) begin
      ts_d          = '0;
      match_count_d = '0;
      drop_count_d  = '0;
      overflow_d    = 1'b0;
    end else begin
      if (en) ts_d = ts_q + TS_WIDTH'(1);
      if (hit) begin
        match_count_d = CNT_WIDTH'(sat_inc(32'(match_count_q), CNT_WIDTH));
      end
      if (drop) begin
        drop_count_d = CNT_WIDTH'(sat_inc(32'(drop_count_q), CNT_WIDTH));
        overflow_d   = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q          <= '0;
      match_count_q <= '0;
      drop_count_q  <= '0;
      overflow_q    <= 1'b0;
    end else begin
      ts_q          <= ts_d;
      match_count_q <= match_count_d;
      drop_count_q  <= drop_count_d;
      overflow_q    <= overflow_d;
    end
  end

  assign match_count = match_count_q;
  assign drop_count  = drop_count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_match_reporter.sv
// Scenario bench for seq_match_reporter: default-width instance plus a
// 4-bit-timestamp instance for the wrap case.
module tb_seq_match_reporter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance
  logic        hit_in, en, clr, evt_ready;
  logic        evt_valid, overflow;
  logic [15:0] evt_ts, match_count, drop_count;
  logic [3:0]  fifo_level;

  // TS_WIDTH=4 instance
  logic        hit4, en4, clr4, ready4;
  logic        evt_valid4, overflow4;
  logic [3:0]  evt_ts4;
  logic [15:0] match_count4, drop_count4;
  logic [3:0]  fifo_level4;

  seq_match_reporter dut (
    .clk (clk), .rst (rst), .hit_in (hit_in), .en (en), .clr (clr),
    .evt_valid (evt_valid), .evt_ready (evt_ready), .evt_ts (evt_ts),
    .fifo_level (fifo_level), .match_count (match_count),
    .drop_count (drop_count), .overflow (overflow)
  );

  seq_match_reporter #(.TS_WIDTH(4)) dut4 (
    .clk (clk), .rst (rst), .hit_in (hit4), .en (en4), .clr (clr4),
    .evt_valid (evt_valid4), .evt_ready (ready4), .evt_ts (evt_ts4),
    .fifo_level (fifo_level4), .match_count (match_count4),
    .drop_count (drop_count4), .overflow (overflow4)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard and reference state for the default instance
  logic [15:0] sb[$];
  logic [3:0]  sb4[$];
  logic [15:0] m_ts, m_match, m_drop;
  logic        m_ovf;

  task automatic model_reset();
    sb.delete();
    m_ts    = '0;
    m_match = '0;
    m_drop  = '0;
    m_ovf   = 1'b0;
  endtask

  // Advance one clock, updating the reference from the inputs of this cycle.
  task automatic tick();
    logic hit_m, pop_m;
    hit_m = en & hit_in;
    pop_m = evt_ready && (sb.size() > 0);
    if (clr) begin
      model_reset();
    end else begin
      if (pop_m) sb.delete(0);
      if (hit_m) begin
        if (m_match != 16'hFFFF) m_match = m_match + 16'd1;
        if (sb.size() < 8) begin
          sb.push_back(m_ts);
        end else begin
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
          m_ovf = 1'b1;
        end
      end
      if (en) m_ts = m_ts + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hit_in = 0; en = 0; clr = 0; evt_ready = 0;
    hit4 = 0; en4 = 0; clr4 = 0; ready4 = 0;
    model_reset();
    #12;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", evt_valid); end
    checks++; if (evt_ts !== 16'd0) begin errors++; $display("FAIL rst_ts got %0d want 0", evt_ts); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rst_level got %0d want 0", fifo_level); end
    checks++; if (match_count !== 16'd0) begin errors++; $display("FAIL rst_match got %0d want 0", match_count); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_drop got %0d want 0", drop_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", overflow); end
    $display("test_reset done");
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_hit();
    en = 1; evt_ready = 1;
    while (m_ts != 16'd5) tick();
    hit_in = 1;
    tick();
    hit_in = 0;
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", evt_valid); end
    checks++;
    if (sb.size() == 0 || evt_ts !== sb[0] || evt_ts !== 16'd5) begin
      errors++; $display("FAIL single_ts got %0d want 5", evt_ts);
    end
    tick();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_popped got %b want 0", evt_valid); end
    checks++; if (match_count !== m_match) begin errors++; $display("FAIL single_match got %0d want %0d", match_count, m_match); end
    $display("test_single_hit ts=%0d match=%0d", evt_ts, match_count);
  endtask

  task automatic test_burst();
    evt_ready = 0;
    while (m_ts != 16'd10) tick();
    hit_in = 1;
    repeat (3) tick();
    hit_in = 0;
    checks++; if (fifo_level !== 4'(sb.size())) begin errors++; $display("FAIL burst_level got %0d want %0d", fifo_level, sb.size()); end
    evt_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (evt_valid !== 1'b1 || sb.size() == 0 || evt_ts !== sb[0]) begin
        errors++; $display("FAIL burst_pop%0d got v=%b ts=%0d want ts=%0d", i, evt_valid, evt_ts, 10 + i);
      end else begin
        $display("burst pop ts=%0d", evt_ts);
      end
      tick();
    end
    evt_ready = 0;
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL burst_drained got %0d want 0", fifo_level); end
  endtask

  task automatic test_overflow();
    clr = 1;
    tick();
    clr = 0;
    checks++; if (match_count !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL clr_stats got m=%0d o=%b want 0/0", match_count, overflow); end
    evt_ready = 0; hit_in = 1;
    repeat (10) tick();
    hit_in = 0;
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level got %0d want 8", fifo_level); end
    checks++; if (drop_count !== m_drop || m_drop !== 16'd2) begin errors++; $display("FAIL ovf_drop got %0d want 2", drop_count); end
    checks++; if (match_count !== m_match || m_match !== 16'd10) begin errors++; $display("FAIL ovf_match got %0d want 10", match_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    checks++; if (sb.size() == 0 || evt_ts !== sb[0]) begin errors++; $display("FAIL ovf_head got %0d want first ts", evt_ts); end
    $display("test_overflow level=%0d drop=%0d match=%0d", fifo_level, drop_count, match_count);
  endtask

  task automatic test_full_pop();
    evt_ready = 1; hit_in = 1;
    tick();
    hit_in = 0; evt_ready = 0;
    checks++; if (drop_count !== m_drop) begin errors++; $display("FAIL fullpop_drop got %0d want %0d", drop_count, m_drop); end
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL fullpop_level got %0d want 8", fifo_level); end
    evt_ready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (evt_valid !== 1'b1 || sb.size() == 0 || evt_ts !== sb[0]) begin
        errors++; $display("FAIL fullpop_drain%0d got v=%b ts=%0d", i, evt_valid, evt_ts);
      end else begin
        $display("drain pop ts=%0d", evt_ts);
      end
      tick();
    end
    evt_ready = 0;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got %b want 0", evt_valid); end
  endtask

  task automatic test_en_clr();
    en = 0; hit_in = 1;
    tick();
    checks++; if (fifo_level !== 4'd0 || match_count !== m_match) begin errors++; $display("FAIL en0_hit got lvl=%0d m=%0d", fifo_level, match_count); end
    en = 1; clr = 1;
    tick();
    clr = 0; hit_in = 0;
    checks++;
    if (evt_valid !== 1'b0 || fifo_level !== 4'd0 || match_count !== 16'd0 ||
        drop_count !== 16'd0 || overflow !== 1'b0 || evt_ts !== 16'd0) begin
      errors++; $display("FAIL clr_hit got v=%b l=%0d m=%0d d=%0d o=%b", evt_valid, fifo_level, match_count, drop_count, overflow);
    end
    hit_in = 1;
    tick();
    hit_in = 0;
    checks++; if (evt_valid !== 1'b1 || sb.size() == 0 || evt_ts !== sb[0]) begin errors++; $display("FAIL clr_ts0 got %0d want 0", evt_ts); end
    $display("test_en_clr first ts after clr=%0d", evt_ts);
  endtask

  task automatic test_wrap();
    en = 0; hit_in = 0; evt_ready = 0;
    en4 = 1;
    repeat (15) tick();
    hit4 = 1;
    sb4.push_back(4'd15);
    tick();
    sb4.push_back(4'd0);
    tick();
    hit4 = 0; en4 = 0;
    ready4 = 1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (evt_valid4 !== 1'b1 || evt_ts4 !== sb4[0]) begin
        errors++; $display("FAIL wrap_pop%0d got v=%b ts=%0d want %0d", i, evt_valid4, evt_ts4, sb4[0]);
      end else begin
        $display("wrap pop ts=%0d", evt_ts4);
      end
      sb4.delete(0);
      tick();
    end
    ready4 = 0;
    checks++; if (evt_valid4 !== 1'b0) begin errors++; $display("FAIL wrap_empty got %b want 0", evt_valid4); end
  endtask

  task automatic test_async_rst();
    en = 1; evt_ready = 1;
    tick();                      // clear leftover entry
    evt_ready = 0; hit_in = 1;
    repeat (3) tick();
    hit_in = 0;
    checks++; if (fifo_level !== 4'd3) begin errors++; $display("FAIL arst_pre got %0d want 3", fifo_level); end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (evt_valid !== 1'b0 || fifo_level !== 4'd0 || match_count !== 16'd0 || drop_count !== 16'd0) begin
      errors++; $display("FAIL arst_now got v=%b l=%0d m=%0d d=%0d", evt_valid, fifo_level, match_count, drop_count);
    end
    #2 rst = 1'b0;
    model_reset();
    hit_in = 1;
    tick();
    hit_in = 0;
    checks++; if (evt_valid !== 1'b1 || sb.size() == 0 || evt_ts !== sb[0]) begin errors++; $display("FAIL arst_first got %0d want 0", evt_ts); end
    $display("test_async_rst first ts=%0d", evt_ts);
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_burst();
    test_overflow();
    test_full_pop();
    test_en_clr();
    test_wrap();
    test_async_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
